debugger_tx: RTL and testbench
==============================

# debugger_tx

Transmit side of the MIPS debug link. When the command receiver raises its send request, this block latches a wide snapshot of pipeline state and serializes it byte by byte into the UART transmit FIFO. It then returns a four-phase completion handshake (`data_sent`) to the receiver. It sits between the debug command FSM and the UART TX FIFO.

## Interface
- `NUM_BYTES`, 220: payload length in bytes; the snapshot is `NUM_BYTES*8` bits wide (1760 at default); minimum 1.
- `clock` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `send_signal` input 1: send request from the command FSM; level, held high until `data_sent` is seen.
- `send_data` input `NUM_BYTES*8`: snapshot payload; byte k = `send_data[8k+7:8k]`.
- `tx_full` input 1: UART TX FIFO full; no write may be issued when sampled high.
- `w_data` output 8: byte presented to the TX FIFO.
- `wr_uart` output 1: single-cycle FIFO write strobe, registered.
- `data_sent` output 1: completion acknowledge, registered level.
- `busy` output 1: high in any state other than IDLE.
- `current_state` output 2: state encoding, exported for debug LEDs.

## Operation
- States: IDLE=0, SEND=1, GAP=2, DONE=3.
- Reset values: state IDLE, `wr_uart`=0, `w_data`=0, `data_sent`=0, `busy`=0, byte index=0, checksum=0.
- IDLE:
  - If `send_data` is sampled while `send_signal`=1, copy the whole vector into an internal shift register, clear the index, and go to SEND.
  - The payload is frozen from this edge on. Later changes on `send_data` are ignored until the next frame.
- SEND:
  - If `tx_full`=0: `wr_uart`<=1, `w_data`<=current byte, then go to GAP.
  - If `tx_full`=1: hold in SEND with `wr_uart`=0. The wait is unbounded.
- GAP:
  - `wr_uart`<=0 and the index increments.
  - If the byte just written was the last one, go to DONE; otherwise go back to SEND.
  - GAP guarantees `wr_uart` is never high on two consecutive cycles, so `tx_full` always reflects the previous write before the next write decision.
- Byte order: byte 0 (LSBs) first, byte `NUM_BYTES-1` last.
- DONE:
  - `data_sent`<=1.
  - When `send_signal` is sampled 0, clear `data_sent` and go to IDLE.
  - If `send_signal` is already low on entry, `data_sent` is still high for exactly one cycle.
- `send_signal` dropping during SEND or GAP is ignored. The frame always completes.
- `reset` mid-frame: the frame is abandoned immediately and all outputs return to their reset values. No partial-byte strobe is issued.
- Index width: `$clog2(NUM_BYTES+2)`. The last-byte compare is against the frame length minus 1, never against index wrap-around.

## Timing
- The request is sampled at edge 0 and the block enters SEND.
- Byte k has `wr_uart` high in the cycle after edge 2k+1 when `tx_full` stays 0.
- `data_sent` rises after edge 2N, where N is the frame length. Peak throughput is one byte per 2 cycles.
- Each cycle `tx_full`=1 is sampled in SEND adds one cycle of latency.
- Minimum DONE-to-IDLE time: 1 cycle. A new request is accepted no earlier than the cycle after IDLE is re-entered.

## Configuration
- `DEBUGGER_TX_FRAMING_EN` defined:
  - Frame length N = `NUM_BYTES+2`.
  - Byte 0 is the sync header 0xA5.
  - Then the payload, then one checksum byte: XOR of all payload bytes, accumulated as each payload byte is written.
  - The header and checksum also go through the SEND/GAP flow control.
- Undefined: N = `NUM_BYTES`, payload only, no checksum logic synthesized.

## Structure
- Shared `debugger_pkg` holds:
  - the state enum for this block (2 bits);
  - the sync header constant 0xA5;
  - the command byte constants already used by the receive FSM (0x31 step, 0x32 run, 0x33 reset), so both ends share one definition.
- No sub-module: byte selection is a right-shift by 8 of the latched register, and the checksum is one 8-bit XOR register, both inline.

## Test plan
Bench uses `NUM_BYTES`=4, `send_data`=0x44332211.
- Request, `tx_full`=0, framing off:
  - writes 0x11, 0x22, 0x33, 0x44 at cycles 2, 4, 6, 8 (no back-to-back strobes);
  - `data_sent` rises after edge 8;
  - `send_signal` low returns to IDLE in 1 cycle.
- `tx_full` held high for 5 cycles before byte 2:
  - the third write is delayed exactly 5 cycles;
  - no strobe is issued while full;
  - all four bytes arrive in order.
- `send_data` changed to 0xFFFFFFFF one cycle after the request: transmitted bytes are still 11 22 33 44.
- `reset` pulsed after the second write: `wr_uart`/`data_sent`/`busy` are 0 next cycle, state is IDLE, and a fresh request retransmits from byte 0x11.
- Framing on: bytes A5 11 22 33 44 44 are written; the checksum is 11^22^33^44 = 0x44; `data_sent` rises after edge 12.
- `send_signal` dropped during GAP: the frame still completes, and `data_sent` is high for exactly one cycle, then IDLE.

Source files
------------

// File: rtl/debugger_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debugger_pkg                                                         |
// | Shared debug-link types and command/framing byte constants.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package debugger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  localparam logic [7:0] c_sync_header = 8'hA5;

  // Command bytes decoded by the receive FSM
  localparam logic [7:0] c_cmd_step  = 8'h31;
  localparam logic [7:0] c_cmd_run   = 8'h32;
  localparam logic [7:0] c_cmd_reset = 8'h33;

endpackage
`default_nettype wire

// File: rtl/debugger_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debugger_tx_if                                                       |
// | Request/payload/FIFO signals between command FSM, TX FIFO and        |
// | debugger_tx. Rev 1.0                                                 |
// +----------------------------------------------------------------------+
interface debugger_tx_if #(
  parameter int NUM_BYTES = 220
);
  logic                   send_signal;
  logic [NUM_BYTES*8-1:0] send_data;
  logic                   tx_full;
  logic [7:0]             w_data;
  logic                   wr_uart;
  logic                   data_sent;
  logic                   busy;
  logic [1:0]             current_state;

  modport master (
    output send_signal, send_data, tx_full,
    input  w_data, wr_uart, data_sent, busy, current_state
  );

  modport slave (
    input  send_signal, send_data, tx_full,
    output w_data, wr_uart, data_sent, busy, current_state
  );
endinterface
`default_nettype wire

// File: rtl/debugger_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debugger_tx                                                          |
// | Latches a pipeline snapshot and serializes it into the UART TX FIFO, |
// | then acknowledges with a four-phase data_sent handshake.             |
// | Option: DEBUGGER_TX_FRAMING_EN adds 0xA5 header and XOR checksum.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module debugger_tx
  import debugger_pkg::*;
#(
  parameter int NUM_BYTES = 220
) (
  input  wire logic     clock,
  input  wire logic     reset,
  debugger_tx_if.slave  bus
);

`ifdef DEBUGGER_TX_FRAMING_EN
  localparam int FRAME_LEN = NUM_BYTES + 2;
`else
  localparam int FRAME_LEN = NUM_BYTES;
`endif
  localparam int IDX_W = $clog2(NUM_BYTES + 2);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_LEN - 1);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [NUM_BYTES*8-1:0] r_shift;
  logic [NUM_BYTES*8-1:0] w_shift_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   r_wr_uart;
  logic                   w_wr_uart_nxt;
  logic [7:0]             r_w_data;
  logic [7:0]             w_w_data_nxt;
  logic                   r_data_sent;
  logic                   w_data_sent_nxt;
  logic [7:0]             w_byte;
  logic                   w_is_payload;
  logic                   w_last;

`ifdef DEBUGGER_TX_FRAMING_EN
  logic [7:0]             r_csum;
  logic [7:0]             w_csum_nxt;
`endif

  assign w_last = (r_idx == c_last_idx);

  // Byte source for the current frame slot
`ifdef DEBUGGER_TX_FRAMING_EN
  always_comb begin
    w_is_payload = 1'b0;
    w_byte       = r_shift[7:0];
    if (r_idx == '0) begin
      w_byte = c_sync_header;
    end else if (w_last) begin
      w_byte = r_csum;
    end else begin
      w_is_payload = 1'b1;
    end
  end
`else
  assign w_byte       = r_shift[7:0];
  assign w_is_payload = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.send_signal) w_state_nxt = ST_SEND;
      ST_SEND: if (!bus.tx_full)    w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = w_last ? ST_DONE : ST_SEND;
      ST_DONE: if (!bus.send_signal) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_wr_uart_nxt   = 1'b0;
    w_w_data_nxt    = r_w_data;
    w_data_sent_nxt = r_data_sent;
`ifdef DEBUGGER_TX_FRAMING_EN
    w_csum_nxt      = r_csum;
`endif
    case (r_state)
      ST_IDLE: begin
        w_data_sent_nxt = 1'b0;
        if (bus.send_signal) begin
          w_shift_nxt = bus.send_data;
          w_idx_nxt   = '0;
`ifdef DEBUGGER_TX_FRAMING_EN
          w_csum_nxt  = '0;
`endif
        end
      end
      ST_SEND: begin
        if (!bus.tx_full) begin
          w_wr_uart_nxt = 1'b1;
          w_w_data_nxt  = w_byte;
          if (w_is_payload) begin
            w_shift_nxt = r_shift >> 8;
`ifdef DEBUGGER_TX_FRAMING_EN
            w_csum_nxt  = r_csum ^ r_shift[7:0];
`endif
          end
        end
      end
      ST_GAP: begin
        w_idx_nxt = r_idx + 1'b1;
        // Raise the ack on the GAP->DONE edge so it lands after edge 2N
        if (w_last) w_data_sent_nxt = 1'b1;
      end
      ST_DONE: begin
        w_data_sent_nxt = bus.send_signal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_wr_uart   <= 1'b0;
      r_w_data    <= '0;
      r_data_sent <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_wr_uart   <= w_wr_uart_nxt;
      r_w_data    <= w_w_data_nxt;
      r_data_sent <= w_data_sent_nxt;
    end
  end

`ifdef DEBUGGER_TX_FRAMING_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_csum <= '0;
    end else begin
      r_csum <= w_csum_nxt;
    end
  end
`endif

  assign bus.w_data        = r_w_data;
  assign bus.wr_uart       = r_wr_uart;
  assign bus.data_sent     = r_data_sent;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.current_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_debugger_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_debugger_tx                                                       |
// | Directed self-checking bench for debugger_tx, NUM_BYTES=4. Rev 1.0   |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_debugger_tx;

  localparam int NUM_BYTES = 4;
`ifdef DEBUGGER_TX_FRAMING_EN
  localparam int N_FRAME = NUM_BYTES + 2;
`else
  localparam int N_FRAME = NUM_BYTES;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  debugger_tx_if #(.NUM_BYTES(NUM_BYTES)) bus ();

  debugger_tx #(.NUM_BYTES(NUM_BYTES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] strb_val[$];
  int         strb_cyc[$];
  int         b2b_cnt = 0;
  logic       prev_wr = 1'b0;

  always @(negedge clock) begin
    if (bus.wr_uart) begin
      strb_val.push_back(bus.w_data);
      strb_cyc.push_back(cyc);
      if (prev_wr) b2b_cnt++;
    end
    prev_wr = bus.wr_uart;
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_bytes [N_FRAME];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full_at: first edge (relative to request edge) that samples tx_full=1
  task automatic run_frame(input string name, input int full_at, input int full_len,
                           input bit change_data, input bit drop_early);
    int e0;
    int rel;
    int done_rel;
    int exp_rel;
    int full_hits;
    done_rel = -1;
    strb_val.delete();
    strb_cyc.delete();
    @(negedge clock);
    bus.send_data   = 32'h44332211;
    bus.send_signal = 1'b1;
    e0 = cyc + 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clock);
      rel = cyc - e0;
      if (change_data && rel == 0) bus.send_data = 32'hFFFFFFFF;
      if (drop_early && rel == 1) bus.send_signal = 1'b0;
      bus.tx_full = (full_len > 0) && (rel + 1 >= full_at) && (rel + 1 < full_at + full_len);
      if (bus.data_sent) begin
        done_rel = rel;
        break;
      end
    end
    bus.tx_full = 1'b0;
    check_eq($sformatf("%s data_sent edge", name), done_rel, 2 * N_FRAME + full_len);
    check_eq($sformatf("%s strobe count", name), strb_val.size(), N_FRAME);
    full_hits = 0;
    for (int k = 0; k < strb_val.size(); k++) begin
      if (full_len > 0 && strb_cyc[k] - e0 >= full_at && strb_cyc[k] - e0 < full_at + full_len)
        full_hits++;
      if (k < N_FRAME) begin
        exp_rel = 2 * k + 1 + ((full_len > 0 && k >= 2) ? full_len : 0);
        check_eq($sformatf("%s byte%0d", name, k), strb_val[k], exp_bytes[k]);
        check_eq($sformatf("%s byte%0d edge", name, k), strb_cyc[k] - e0, exp_rel);
      end
    end
    if (full_len > 0) check_eq($sformatf("%s strobes while full", name), full_hits, 0);
    if (!drop_early) begin
      @(negedge clock);
      check_eq($sformatf("%s ack held", name), bus.data_sent, 1);
      check_eq($sformatf("%s state DONE", name), bus.current_state, 3);
      bus.send_signal = 1'b0;
    end
    @(negedge clock);
    check_eq($sformatf("%s ack cleared", name), bus.data_sent, 0);
    check_eq($sformatf("%s state IDLE", name), bus.current_state, 0);
    check_eq($sformatf("%s busy low", name), bus.busy, 0);
  endtask

  initial begin
`ifdef DEBUGGER_TX_FRAMING_EN
    exp_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    bus.send_signal = 1'b0;
    bus.send_data   = '0;
    bus.tx_full     = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("reset wr_uart", bus.wr_uart, 0);
    check_eq("reset w_data", bus.w_data, 0);
    check_eq("reset data_sent", bus.data_sent, 0);
    check_eq("reset busy", bus.busy, 0);
    check_eq("reset state", bus.current_state, 0);
    reset = 1'b0;
    @(negedge clock);

    run_frame("basic", 0, 0, 1'b0, 1'b0);
    run_frame("full", 5, 5, 1'b0, 1'b0);
    run_frame("frozen", 0, 0, 1'b1, 1'b0);

    // Reset after the second strobe, then a fresh frame
    @(negedge clock);
    bus.send_data   = 32'h44332211;
    bus.send_signal = 1'b1;
    repeat (4) @(negedge clock);
    check_eq("pre-reset strobe", bus.wr_uart, 1);
    reset           = 1'b1;
    bus.send_signal = 1'b0;
    @(negedge clock);
    check_eq("midreset wr_uart", bus.wr_uart, 0);
    check_eq("midreset data_sent", bus.data_sent, 0);
    check_eq("midreset busy", bus.busy, 0);
    check_eq("midreset state", bus.current_state, 0);
    reset = 1'b0;
    @(negedge clock);
    run_frame("retx", 0, 0, 1'b0, 1'b0);

    run_frame("drop", 0, 0, 1'b0, 1'b1);

    check_eq("back-to-back strobes", b2b_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
